// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: muxes init/refresh/write/read sequencers onto one SDRAM port.
// Latency: grant registered, 1 cycle after request sampled in ARBIT; command mux combinational.
// Backpressure: fixed priority refresh > write > read, no preemption; losers hold requests until next ARBIT.
module sdram_arbit #(
   parameter int         DATA_W  = 16,
   parameter logic [3:0] NOP_CMD = 4'b0111
) (
   input  logic              clk_100m,
   input  logic              sys_rst_n,
   input  logic [3:0]        init_cmd,
   input  logic [1:0]        init_ba,
   input  logic [12:0]       init_addr,
   input  logic              init_end,
   input  logic              aref_req,
   input  logic [3:0]        aref_cmd,
   input  logic [1:0]        aref_ba,
   input  logic [12:0]       aref_addr,
   input  logic              aref_end,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [1:0]        wr_ba,
   input  logic [12:0]       wr_addr,
   input  logic              wr_end,
   input  logic              wr_sdram_en,
   input  logic [DATA_W-1:0] wr_sdram_data,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [1:0]        rd_ba,
   input  logic [12:0]       rd_addr,
   input  logic              rd_end,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [1:0]        sdram_ba,
   output logic [12:0]       sdram_addr,
   inout  wire  [DATA_W-1:0] sdram_dq
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       aref_en_q, aref_en_d;
   logic       wr_en_q, wr_en_d;
   logic       rd_en_q, rd_en_d;
   logic [3:0] sdram_cmd;

   // State and grant registers; reset drops every grant immediately.
   always_ff @(posedge clk_100m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         aref_en_q <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         aref_en_q <= aref_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   // Next state: wait for init, fixed-priority pick, hold the owner until its own end pulse.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (init_end) state_d = ST_ARBIT;
         ST_ARBIT: begin
            if (aref_req)    state_d = ST_AREF;
            else if (wr_req) state_d = ST_WRITE;
            else if (rd_req) state_d = ST_READ;
         end
         ST_AREF:  if (aref_end) state_d = ST_ARBIT;
         ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
         ST_READ:  if (rd_end)   state_d = ST_ARBIT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs: grants follow the next state so the registered copy equals the current state;
   // command/bank/address come straight from whichever sequencer owns the state.
   always_comb begin
      aref_en_d  = (state_d == ST_AREF);
      wr_en_d    = (state_d == ST_WRITE);
      rd_en_d    = (state_d == ST_READ);
      sdram_cmd  = NOP_CMD;
      sdram_ba   = 2'b11;
      sdram_addr = 13'h1FFF;
      case (state_q)
         ST_IDLE: begin
            sdram_cmd  = init_cmd;
            sdram_ba   = init_ba;
            sdram_addr = init_addr;
         end
         ST_AREF: begin
            sdram_cmd  = aref_cmd;
            sdram_ba   = aref_ba;
            sdram_addr = aref_addr;
         end
         ST_WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_ba   = wr_ba;
            sdram_addr = wr_addr;
         end
         ST_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_ba   = rd_ba;
            sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   assign aref_en   = aref_en_q;
   assign wr_en     = wr_en_q;
   assign rd_en     = rd_en_q;
   assign sdram_cke = 1'b1;
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sdram_cmd;

   // The write sequencer owns the data bus only while granted and actively driving.
   assign sdram_dq = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

   localparam logic [3:0] NOP = 4'b0111;

   logic        clk_100m = 1'b0;
   logic        sys_rst_n;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [12:0] init_addr;
   logic        init_end;
   logic        aref_req;
   logic [3:0]  aref_cmd  = 4'b0001;
   logic [1:0]  aref_ba   = 2'b01;
   logic [12:0] aref_addr = 13'h0400;
   logic        aref_end;
   logic        wr_req;
   logic [3:0]  wr_cmd    = 4'b0100;
   logic [1:0]  wr_ba     = 2'b10;
   logic [12:0] wr_addr   = 13'h0123;
   logic        wr_end;
   logic        wr_sdram_en;
   logic [15:0] wr_sdram_data;
   logic        rd_req;
   logic [3:0]  rd_cmd    = 4'b0101;
   logic [1:0]  rd_ba     = 2'b00;
   logic [12:0] rd_addr   = 13'h0456;
   logic        rd_end;
   logic        aref_en, wr_en, rd_en, sdram_cke;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   wire  [15:0] sdram_dq;
   logic [3:0]  cmd;

   int n_cmp = 0;
   int n_bad = 0;

   // Released bus reads back all ones, so an undriven dq is distinguishable from a driven value.
   for (genvar gi = 0; gi < 16; gi++) begin : g_pu
      pullup pu (sdram_dq[gi]);
   end

   always #5 clk_100m = ~clk_100m;

   assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

   sdram_arbit #(.DATA_W(16), .NOP_CMD(4'b0111)) dut (
      .clk_100m(clk_100m), .sys_rst_n(sys_rst_n),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_end(aref_end),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_end(wr_end),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
   );

   task automatic tick;
      @(posedge clk_100m);
      #1;
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0; init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0ABC; init_end = 1'b0;
      aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
      wr_sdram_en = 1'b1; wr_sdram_data = 16'h1234;
      #12;
      n_cmp++;
      if ({aref_en, wr_en, rd_en} !== 3'b000) begin
         n_bad++; $display("FAIL reset_grants got=%b want=000", {aref_en, wr_en, rd_en});
      end
      n_cmp++;
      if ({cmd, sdram_ba, sdram_addr} !== {4'b0010, 2'b01, 13'h0ABC}) begin
         n_bad++; $display("FAIL reset_mux got=%h/%h/%h want=2/1/abc", cmd, sdram_ba, sdram_addr);
      end
      n_cmp++;
      if (sdram_cke !== 1'b1 || sdram_dq !== 16'hFFFF) begin
         n_bad++; $display("FAIL reset_cke_dq got=%b/%h want=1/ffff", sdram_cke, sdram_dq);
      end
   endtask

   task automatic test_startup;
      int bad_en = 0;
      int bad_cmd = 0;
      @(negedge clk_100m);
      sys_rst_n = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         init_cmd = 4'(i);
         tick;
         if (wr_en !== 1'b0) bad_en++;
         if (cmd !== 4'(i)) bad_cmd++;
      end
      n_cmp++;
      if (bad_en != 0) begin
         n_bad++; $display("FAIL startup_no_grant got=%0d cycles with wr_en want=0", bad_en);
      end
      n_cmp++;
      if (bad_cmd != 0) begin
         n_bad++; $display("FAIL startup_track_init got=%0d mismatched cycles want=0", bad_cmd);
      end
      init_end = 1'b1;
      tick;
      n_cmp++;
      if ({cmd, sdram_ba, sdram_addr, wr_en} !== {NOP, 2'b11, 13'h1FFF, 1'b0}) begin
         n_bad++; $display("FAIL startup_arbit got=%h/%h/%h/%b want=7/3/1fff/0", cmd, sdram_ba, sdram_addr, wr_en);
      end
      tick;
      n_cmp++;
      if ({wr_en, cmd, sdram_ba, sdram_addr} !== {1'b1, 4'b0100, 2'b10, 13'h0123}) begin
         n_bad++; $display("FAIL startup_write got=%b/%h/%h/%h want=1/4/2/123", wr_en, cmd, sdram_ba, sdram_addr);
      end
      wr_req = 1'b0; wr_end = 1'b1;
      tick;
      wr_end = 1'b0;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b000, NOP}) begin
         n_bad++; $display("FAIL startup_back_arbit got=%b/%h want=000/7", {aref_en, wr_en, rd_en}, cmd);
      end
   endtask

   task automatic test_contention;
      aref_req = 1; wr_req = 1; rd_req = 1;
      tick;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b100, 4'b0001}) begin
         n_bad++; $display("FAIL contention_aref got=%b/%h want=100/1", {aref_en, wr_en, rd_en}, cmd);
      end
      // stray end from a non-granted sequencer
      wr_end = 1'b1;
      tick;
      wr_end = 1'b0;
      n_cmp++;
      if ({aref_en, wr_en, cmd} !== {2'b10, 4'b0001}) begin
         n_bad++; $display("FAIL stray_end got=%b/%h want=10/1", {aref_en, wr_en}, cmd);
      end
      aref_req = 0; aref_end = 1;
      tick;
      aref_end = 0;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b000, NOP}) begin
         n_bad++; $display("FAIL contention_gap1 got=%b/%h want=000/7", {aref_en, wr_en, rd_en}, cmd);
      end
      tick;
      n_cmp++;
      if ({aref_en, wr_en, rd_en} !== 3'b010) begin
         n_bad++; $display("FAIL contention_write got=%b want=010", {aref_en, wr_en, rd_en});
      end
      wr_req = 0; wr_end = 1;
      tick;
      wr_end = 0;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b000, NOP}) begin
         n_bad++; $display("FAIL contention_gap2 got=%b/%h want=000/7", {aref_en, wr_en, rd_en}, cmd);
      end
      tick;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd, sdram_addr} !== {3'b001, 4'b0101, 13'h0456}) begin
         n_bad++; $display("FAIL contention_read got=%b/%h/%h want=001/5/456", {aref_en, wr_en, rd_en}, cmd, sdram_addr);
      end
      wr_sdram_en = 1; wr_sdram_data = 16'hA5A5;
      #1;
      n_cmp++;
      if (sdram_dq !== 16'hFFFF) begin
         n_bad++; $display("FAIL dq_in_read got=%h want=ffff(z)", sdram_dq);
      end
      rd_req = 0; rd_end = 1;
      tick;
      rd_end = 0;
      n_cmp++;
      if (rd_en !== 1'b0 || sdram_dq !== 16'hFFFF) begin
         n_bad++; $display("FAIL dq_in_arbit got=%b/%h want=0/ffff", rd_en, sdram_dq);
      end
   endtask

   task automatic test_no_preempt;
      wr_req = 1; wr_sdram_en = 1; wr_sdram_data = 16'hA5A5;
      tick;
      wr_req = 0;
      n_cmp++;
      if (wr_en !== 1'b1 || sdram_dq !== 16'hA5A5) begin
         n_bad++; $display("FAIL dq_write got=%b/%h want=1/a5a5", wr_en, sdram_dq);
      end
      wr_sdram_en = 0;
      #1;
      n_cmp++;
      if (sdram_dq !== 16'hFFFF) begin
         n_bad++; $display("FAIL dq_write_off got=%h want=ffff(z)", sdram_dq);
      end
      tick; tick; tick;
      aref_req = 1;
      tick; tick;
      n_cmp++;
      if ({aref_en, wr_en, cmd} !== {2'b01, 4'b0100}) begin
         n_bad++; $display("FAIL no_preempt got=%b/%h want=01/4", {aref_en, wr_en}, cmd);
      end
      wr_end = 1;
      tick;
      wr_end = 0;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b000, NOP}) begin
         n_bad++; $display("FAIL preempt_gap got=%b/%h want=000/7", {aref_en, wr_en, rd_en}, cmd);
      end
      tick;
      n_cmp++;
      if ({aref_en, wr_en, rd_en} !== 3'b100) begin
         n_bad++; $display("FAIL preempt_aref got=%b want=100", {aref_en, wr_en, rd_en});
      end
      aref_req = 0; aref_end = 1;
      tick;
      aref_end = 0;
   endtask

   task automatic test_reset_mid_read;
      rd_req = 1;
      tick;
      n_cmp++;
      if (rd_en !== 1'b1) begin
         n_bad++; $display("FAIL mid_read_grant got=%b want=1", rd_en);
      end
      rd_req = 0;
      #1 sys_rst_n = 0;
      #1;
      n_cmp++;
      if (rd_en !== 1'b0 || {cmd, sdram_addr} !== {init_cmd, 13'h0ABC}) begin
         n_bad++; $display("FAIL mid_read_reset got=%b/%h/%h want=0/%h/abc", rd_en, cmd, sdram_addr, init_cmd);
      end
      #1 sys_rst_n = 1;
      tick;
      n_cmp++;
      if ({aref_en, wr_en, rd_en, cmd} !== {3'b000, NOP}) begin
         n_bad++; $display("FAIL post_reset_arbit got=%b/%h want=000/7", {aref_en, wr_en, rd_en}, cmd);
      end
   endtask

   initial begin
      test_reset;
      test_startup;
      test_contention;
      test_no_preempt;
      test_reset_mid_read;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
